// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit loads/stores over a 16-bit SRAM as two halfword accesses.
// Freezes the pipeline until the access finishes, then releases it for one cycle.
module mem_stage_sram #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       st_val,
    input  logic [3:0]        dest,
    input  logic [15:0]       sram_dq_in,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [31:0]       alu_result_out,
    output logic [3:0]        dest_out,
    output logic [31:0]       mem_result,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              cnt_last;
    logic              req;
    logic              start;
    logic              in_lo;
    logic              in_hi;
    logic              lo_end;
    logic              hi_end;

    logic              is_store;
    logic [15:0]       st_hi;
    logic [ADDR_W-1:0] lo_lat;
    logic [ADDR_W-1:0] hi_addr;

    logic [31:0]       offset;
    logic [31:0]       lo_full;
    logic [ADDR_W-1:0] lo_addr;
    logic              unused_bits;

    assign wb_en_out      = wb_en;
    assign mem_r_en_out   = mem_r_en;
    assign alu_result_out = alu_result;
    assign dest_out       = dest;

    assign req = mem_r_en | mem_w_en;

    // Halfword address of the low half: ((addr - base) >> 2) << 1.
    assign offset  = alu_result - BASE_ADDR;
    assign lo_full = {1'b0, offset[31:2], 1'b0};
    assign lo_addr = lo_full[ADDR_W-1:0];
    assign hi_addr = {lo_lat[ADDR_W-1:1], 1'b1};

    assign unused_bits = ^{offset[1:0], lo_full[31:ADDR_W], lo_lat[0]};

    assign in_lo    = (state == S_LO);
    assign in_hi    = (state == S_HI);
    assign cnt_last = (cnt == CNT_LAST);
    assign start    = (state == S_IDLE) & req;
    assign lo_end   = in_lo & cnt_last;
    assign hi_end   = in_hi & cnt_last;

    // Stall while a request waits in IDLE or either halfword is in flight.
    assign freeze = rst & (start | in_lo | in_hi);

    // Strobes follow the phase directly so reset drops them at once.
    assign sram_we_n  = ~((in_lo | in_hi) & is_store);
    assign sram_dq_oe = (in_lo | in_hi) & is_store;

    // Next state and wait counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (req) begin
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (cnt_last) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HI: begin
                if (cnt_last) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture op type, address and upper store data when the access starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_store <= 1'b0;
            st_hi    <= '0;
            lo_lat   <= '0;
        end else if (start) begin
            is_store <= mem_w_en;
            st_hi    <= st_val[31:16];
            lo_lat   <= lo_addr;
        end
    end

    // SRAM address/data are loaded on phase entry and held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else if (start) begin
            sram_addr <= lo_addr;
            if (mem_w_en) begin
                sram_dq_out <= st_val[15:0];
            end
        end else if (lo_end) begin
            sram_addr <= hi_addr;
            if (is_store) begin
                sram_dq_out <= st_hi;
            end
        end
    end

    // Load data halves are sampled on the last cycle of each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_result <= '0;
        end else if (!is_store) begin
            if (lo_end) begin
                mem_result[15:0] <= sram_dq_in;
            end
            if (hi_end) begin
                mem_result[31:16] <= sram_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a small behavioural SRAM.
// Default parameters: WAIT_CYCLES=2, ADDR_W=18, BASE_ADDR=1024.
module tb_mem_stage_sram;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic [15:0] sram_dq_in;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_result_out;
    logic [3:0]  dest_out;
    logic [31:0] mem_result;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int checks;
    int errors;
    logic [31:0] exp_res;

    logic [15:0] sram_mem [0:63];

    mem_stage_sram dut (
        .clk            (clk),
        .rst            (rst),
        .wb_en          (wb_en),
        .mem_r_en       (mem_r_en),
        .mem_w_en       (mem_w_en),
        .alu_result     (alu_result),
        .st_val         (st_val),
        .dest           (dest),
        .sram_dq_in     (sram_dq_in),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .alu_result_out (alu_result_out),
        .dest_out       (dest_out),
        .mem_result     (mem_result),
        .freeze         (freeze),
        .sram_addr      (sram_addr),
        .sram_dq_out    (sram_dq_out),
        .sram_dq_oe     (sram_dq_oe),
        .sram_we_n      (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = sram_mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr[5:0]] <= sram_dq_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [17:0] ea,
                       input logic [15:0] ed, input bit cd,
                       input bit ewe, input bit eoe, input bit efr);
        @(negedge clk);
        chk({tag, ".addr"}, 32'(sram_addr), 32'(ea));
        if (cd) chk({tag, ".dq"}, 32'(sram_dq_out), 32'(ed));
        chk({tag, ".we_n"}, 32'(sram_we_n), 32'(ewe));
        chk({tag, ".oe"}, 32'(sram_dq_oe), 32'(eoe));
        chk({tag, ".freeze"}, 32'(freeze), 32'(efr));
    endtask

    // One full op: IDLE(req), 2 LO, 2 HI, DONE. Inputs are driven now.
    task automatic run_op(input string tag, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] sv,
                          input bit from_done, input logic [17:0] elo,
                          input logic [31:0] eres);
        mem_r_en   = r;
        mem_w_en   = w;
        alu_result = a;
        st_val     = sv;
        if (from_done) @(negedge clk);
        else #1;
        chk({tag, ".idle_freeze"}, 32'(freeze), 32'd1);
        chk({tag, ".idle_we_n"}, 32'(sram_we_n), 32'd1);
        cyc({tag, ".lo0"}, elo, sv[15:0], w, !w, w, 1'b1);
        alu_result = 32'h0000_9990;
        st_val     = 32'h0BAD_0BAD;
        cyc({tag, ".lo1"}, elo, sv[15:0], w, !w, w, 1'b1);
        cyc({tag, ".hi0"}, elo | 18'd1, sv[31:16], w, !w, w, 1'b1);
        cyc({tag, ".hi1"}, elo | 18'd1, sv[31:16], w, !w, w, 1'b1);
        cyc({tag, ".done"}, elo | 18'd1, sv[31:16], w, 1'b1, 1'b0, 1'b0);
        chk({tag, ".result"}, mem_result, eres);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_res    = 32'd0;
        rst        = 1'b0;
        wb_en      = 1'b0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'd0;
        st_val     = 32'd0;
        dest       = 4'd0;
        for (int i = 0; i < 64; i++) sram_mem[i] = 16'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.freeze", 32'(freeze), 32'd0);
        chk("rst.we_n", 32'(sram_we_n), 32'd1);
        chk("rst.oe", 32'(sram_dq_oe), 32'd0);
        chk("rst.addr", 32'(sram_addr), 32'd0);
        chk("rst.dq", 32'(sram_dq_out), 32'd0);
        chk("rst.result", mem_result, 32'd0);
        mem_w_en = 1'b1;
        #1;
        chk("rst.freeze_req", 32'(freeze), 32'd0);
        mem_w_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Store 0xDEADBEEF at 1028 -> halfwords 2,3
        dest = 4'd3;
        run_op("st1", 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0,
               18'd2, 32'd0);

        // Load it back
        wb_en = 1'b1;
        dest  = 4'd5;
        exp_res = 32'hDEAD_BEEF;
        run_op("ld1", 1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 18'd2, exp_res);

        // Non-memory op
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'h55;
        dest       = 4'd7;
        #1;
        chk("nm.alu_out", alu_result_out, 32'h55);
        chk("nm.dest_out", 32'(dest_out), 32'd7);
        chk("nm.wb_out", 32'(wb_en_out), 32'd1);
        chk("nm.r_out", 32'(mem_r_en_out), 32'd0);
        chk("nm.freeze_done", 32'(freeze), 32'd0);
        cyc("nm.c0", 18'd3, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("nm.c1", 18'd3, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nm.result", mem_result, exp_res);

        // Back-to-back stores at 1024 and 1032
        wb_en = 1'b0;
        run_op("st2", 1'b0, 1'b1, 32'd1024, 32'h1111_2222, 1'b0,
               18'd0, exp_res);
        run_op("st3", 1'b0, 1'b1, 32'd1032, 32'h3333_4444, 1'b1,
               18'd4, exp_res);
        chk("st.mem0", 32'(sram_mem[0]), 32'h2222);
        chk("st.mem1", 32'(sram_mem[1]), 32'h1111);
        chk("st.mem4", 32'(sram_mem[4]), 32'h4444);
        chk("st.mem5", 32'(sram_mem[5]), 32'h3333);

        // Reset during the HI phase of a store
        mem_w_en   = 1'b1;
        alu_result = 32'd1028;
        st_val     = 32'hCAFE_F00D;
        cyc("rh.idle", 18'd5, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("rh.lo0", 18'd2, 16'hF00D, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("rh.lo1", 18'd2, 16'hF00D, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("rh.hi0", 18'd3, 16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rh.we_n", 32'(sram_we_n), 32'd1);
        chk("rh.oe", 32'(sram_dq_oe), 32'd0);
        chk("rh.freeze", 32'(freeze), 32'd0);
        chk("rh.addr", 32'(sram_addr), 32'd0);
        chk("rh.dq", 32'(sram_dq_out), 32'd0);
        chk("rh.result", mem_result, 32'd0);
        exp_res = 32'd0;
        @(negedge clk);
        mem_w_en = 1'b0;
        rst      = 1'b1;
        cyc("rh.post0", 18'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rh.post1", 18'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("rh.post2", 18'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load from 1032 -> halfwords 4,5
        exp_res = 32'h3333_4444;
        run_op("ld2", 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 18'd4, exp_res);

        // Both enables: performed as a store, mem_result untouched
        run_op("both", 1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b1,
               18'd0, exp_res);

        // Read the word back
        exp_res = 32'h1234_5678;
        run_op("ld3", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 18'd0, exp_res);

        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        cyc("end.idle", 18'd1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
